// File: rtl/y_mux4to1.sv
// y_mux4to1: SIZE-bit 4:1 multiplexer with a combinational output and a registered copy.
// z is built as a two-level tree of bitwise 2:1 muxes. zq is z delayed by one clock and
// is cleared by an asynchronous active-low reset. Only zq depends on clk and rst_n.
module y_mux4to1 #(
  parameter int SIZE = 2
) (
  output logic [SIZE-1:0] z,
  input  logic [SIZE-1:0] a0,
  input  logic [SIZE-1:0] a1,
  input  logic [SIZE-1:0] a2,
  input  logic [SIZE-1:0] a3,
  input  logic [1:0]      c,
  input  logic            clk,
  input  logic            rst_n,
  output logic [SIZE-1:0] zq
);

  logic [SIZE-1:0] lo;
  logic [SIZE-1:0] hi;

  // Bitwise 2:1 mux: (s AND b) OR (NOT s AND a). The extra (a AND b) consensus term
  // is logically redundant, but it keeps the bit at its known value when s is X/Z
  // and both candidates agree. It also keeps the output free of glitches while s switches.
  function automatic logic [SIZE-1:0] mux2(
    input logic [SIZE-1:0] a,
    input logic [SIZE-1:0] b,
    input logic            s
  );
    return ({SIZE{s}} & b) | ({SIZE{~s}} & a) | (a & b);
  endfunction

  // First level picks within each pair using c[0]. The second level picks the pair using c[1].
  always_comb begin
    lo = mux2(a0, a1, c[0]);
    hi = mux2(a2, a3, c[0]);
    z  = mux2(lo, hi, c[1]);
  end

  // Registered copy of z. An asynchronous clear discards the held value immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zq <= '0;
    end else begin
      zq <= z;
    end
  end

endmodule

// File: tb/tb_y_mux4to1.sv
// tb_y_mux4to1: self-checking bench for y_mux4to1 at SIZE=32.
// Directed vectors carry hand-computed expectations. A reference model selects a
// candidate by indexing an array with c and tracks the one-cycle-delayed copy.
// A compare process checks both outputs against that model on every falling edge.
module tb_y_mux4to1;

  localparam int SIZE = 32;

  logic [SIZE-1:0] z;
  logic [SIZE-1:0] a0;
  logic [SIZE-1:0] a1;
  logic [SIZE-1:0] a2;
  logic [SIZE-1:0] a3;
  logic [1:0]      c;
  logic            clk;
  logic            rst_n;
  logic [SIZE-1:0] zq;

  logic            clk_en;
  logic            compare_en;
  logic [SIZE-1:0] exp_zq;
  logic            probe;
  logic            four_state;
  int              n_cmp;
  int              n_bad;

  y_mux4to1 #(.SIZE(SIZE)) dut (
    .z     (z),
    .a0    (a0),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .c     (c),
    .clk   (clk),
    .rst_n (rst_n),
    .zq    (zq)
  );

  // Gated clock: the clock can be held idle low while reset behaviour is probed.
  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  // Reference selection: the candidate whose index is the select value.
  function automatic logic [SIZE-1:0] model_z(
    input logic [SIZE-1:0] v0,
    input logic [SIZE-1:0] v1,
    input logic [SIZE-1:0] v2,
    input logic [SIZE-1:0] v3,
    input logic [1:0]      sel
  );
    logic [SIZE-1:0] cand [4];
    cand[0] = v0;
    cand[1] = v1;
    cand[2] = v2;
    cand[3] = v3;
    return cand[sel];
  endfunction

  // Reference for zq: it captures the selected value at each edge outside reset and is cleared as soon as reset asserts.
  always @(posedge clk) exp_zq = rst_n ? model_z(a0, a1, a2, a3, c) : '0;
  always @(negedge rst_n) exp_zq = '0;

  task automatic check_output(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [SIZE-1:0] v0, input logic [SIZE-1:0] v1,
                                input logic [SIZE-1:0] v2, input logic [SIZE-1:0] v3,
                                input logic [1:0] sel);
    a0 = v0;
    a1 = v1;
    a2 = v2;
    a3 = v3;
    c  = sel;
  endtask

  // Compare both outputs against the model once per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (compare_en) begin
      check_output("cyc_z", z, model_z(a0, a1, a2, a3, c));
      check_output("cyc_zq", zq, exp_zq);
    end
  end

  // Check X selects on the bits where the two reachable candidates agree.
  // On a four-state simulator, also require X on the bits where the candidates differ.
  task automatic check_xsel(input string name, input logic [SIZE-1:0] ca, input logic [SIZE-1:0] cb);
    logic [SIZE-1:0] agree;
    logic [SIZE-1:0] exp;
    agree = ~(ca ^ cb);
    exp = ca;
    for (int i = 0; i < SIZE; i++) begin
      if (!agree[i]) exp[i] = 1'bx;
    end
    if (four_state) check_output(name, z, exp);
    else check_output(name, z & agree, ca & agree);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clk_en = 1'b0;
    compare_en = 1'b0;
    probe = 1'bx;
    four_state = (probe === 1'bx);
    rst_n = 1'b0;
    apply_stimulus(32'h12153524, 32'hC0895E81, 32'h8484D609, 32'hB1F05663, 2'b00);

    // Reset with the clock idle. z is unaffected, and every select value maps to its own input.
    #1;
    check_output("reset_zq", zq, '0);
    check_output("ver1_z", z, 32'h12153524);
    c = 2'b01; #1;
    check_output("ver2_z", z, 32'hC0895E81);
    c = 1'b1; #1;
    check_output("ver2_z_1bit", z, 32'hC0895E81);
    c = 2'b10; #1;
    check_output("ver3_z10", z, 32'h8484D609);
    c = 2'b11; #1;
    check_output("ver3_z11", z, 32'hB1F05663);
    check_output("reset_zq_hold", zq, '0);

    // Release reset with the clock idle. Then one edge loads zq, and a mid-cycle select change leaves zq alone.
    rst_n = 1'b1; #1;
    check_output("release_no_edge_zq", zq, '0);
    clk_en = 1'b1;
    @(posedge clk); #1;
    check_output("ver4_zq_load", zq, 32'hB1F05663);
    #1 c = 2'b00; #1;
    check_output("ver4_z_change", z, 32'h12153524);
    check_output("ver4_zq_hold", zq, 32'hB1F05663);
    @(posedge clk); #1;
    check_output("ver4_zq_next", zq, 32'h12153524);
    compare_en = 1'b1;

    // Walk every select value with bit-distinct data so any crossed bit or swapped input shows up.
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #2;
      apply_stimulus(32'h0000FFFF, 32'h00FF00FF, 32'h0F0F0F0F, 32'h33333333, 2'(s));
    end

    // Assert reset mid-operation: the held value is discarded at once and stays cleared across an edge.
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check_output("async_reset_zq", zq, '0);
    check_output("reset_z_live", z, 32'h33333333);
    @(posedge clk); #1;
    check_output("reset_hold_zq", zq, '0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("post_reset_zq", zq, 32'h33333333);

    // Random vectors: check z directly each time. The compare process follows zq.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #2;
      apply_stimulus($urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
      #1;
      check_output("rand_z", z, model_z(a0, a1, a2, a3, c));
    end
    @(posedge clk); #2;

    // Unknown select bits: agreeing candidates pass through, and differing bits go unknown.
    compare_en = 1'b0;
    apply_stimulus(32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'h0000FFFF, 2'bx0);
    #1;
    check_output("xsel_agree", z, 32'hFFFF0000);
    apply_stimulus(32'hFFFF0000, 32'hFF00FF00, 32'hFF00FF00, 32'h12345678, 2'bx0);
    #1;
    check_xsel("xsel_hi_differ", 32'hFFFF0000, 32'hFF00FF00);
    c = 2'b0x; #1;
    check_xsel("xsel_lo_differ", 32'hFFFF0000, 32'hFF00FF00);

    @(negedge clk);
    clk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/y_mux4to1.md
Y_MUX4TO1 -- requirements
Module: y_mux4to1

Interface
REQ-001 Parameter SIZE, default 2: data path width in bits; the system instantiation uses SIZE=32.
REQ-002 clk  input  1  single clock; rising-edge active; drives only the registered output zq.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 z  output  SIZE  combinational mux result.
REQ-005 a0  input  SIZE  data input selected when c=2'b00.
REQ-006 a1  input  SIZE  data input selected when c=2'b01.
REQ-007 a2  input  SIZE  data input selected when c=2'b10.
REQ-008 a3  input  SIZE  data input selected when c=2'b11.
REQ-009 c  input  2  select; c[1] is the MSB.
REQ-010 zq  output  SIZE  registered copy of z.
REQ-011 Port declaration order SHALL be z, a0, a1, a2, a3, c, clk, rst_n, zq, so a 6-port positional instantiation (z,a0,a1,a2,a3,c) is legal.
  - A 1-bit signal driving c zero-extends: 0 selects a0, 1 selects a1.
  - Unconnected clk, rst_n and zq SHALL NOT affect z.

Function
REQ-012 z SHALL equal a0/a1/a2/a3 for c = 00/01/10/11 respectively, on all SIZE bits.
REQ-013 z SHALL be purely combinational: zero cycles of latency, settled within 1 simulation time unit of any input change, no dependence on clk or rst_n.
REQ-014 Structure SHALL be a two-level tree of SIZE-wide 2:1 muxes, each bit being (s AND b) OR (NOT s AND a):
  - lo = c[0] ? a1 : a0
  - hi = c[0] ? a3 : a2
  - z = c[1] ? hi : lo
REQ-015 X/Z on a select bit SHALL give z bits equal to the candidate value where the candidates agree, and X where they differ.
  - No select value SHALL default silently to a0.
REQ-016 Each bit of z SHALL depend only on the same bit index of a0..a3; there SHALL be no cross-bit logic.
REQ-017 On each rising clk edge with rst_n high, zq SHALL load the current z; latency is 1 cycle.
REQ-018 A change of z between edges SHALL NOT alter zq until the next rising edge.
REQ-019 The design SHALL contain no other state and SHALL have no handshake; every select value is valid on every cycle.

Reset
REQ-020 rst_n low SHALL force zq to all-zeros immediately, without waiting for a clock edge.
REQ-021 While rst_n is low, zq SHALL hold 0 regardless of clk.
REQ-022 Reset SHALL NOT affect z.
REQ-023 Reset deassertion coinciding with a rising clk edge SHALL leave zq at 0 for that edge; zq loads on the first edge after deassertion.
REQ-024 Reset asserted mid-operation SHALL discard the held zq value.

Verification
REQ-025 Common stimulus for VER-1 to VER-4: a0=32'h12153524, a1=32'hC0895E81, a2=32'h8484D609, a3=32'hB1F05663 (SIZE=32).
  - VER-1: c=2'b00, wait #1 -> z=32'h12153524.
  - VER-2: c=2'b01 -> z=32'hC0895E81; a 1-bit driver c=1'b1 gives the same result.
  - VER-3: c=2'b10 -> z=32'h8484D609; then c=2'b11 -> z=32'hB1F05663.
  - VER-4: rst_n=0 with clk idle -> zq=0 at once; release, c=2'b11, one rising edge -> zq=32'hB1F05663; change c to 2'b00 mid-cycle -> z=32'h12153524 at once, zq unchanged until the next edge.
REQ-026 VER-5: 10 random vectors on a0..a3 and c; check every bit of z against the REQ-012 golden selection with ===.
REQ-027 VER-6: a0=a1=32'hFFFF0000, c=2'bx0 -> z=32'hFFFF0000; a0 differs from a1 -> X on the differing bits.
